psum_drain_requant: RTL and testbench

//  Drains final psums from the single-cluster GLB psum bank after the cluster's compute_done pulse.

---
 rtl/psum_drain_requant_if.sv | 35 +++
 rtl/psum_drain_requant.sv | 189 ++++++++++++++++++
 tb/tb_psum_drain_requant.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_drain_requant_if.sv
// GLB psum read port and requantised output stream of the psum drain block.
// master = drain block (issues reads, produces the stream); slave = GLB + downstream consumer.
interface psum_drain_requant_if #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10,
  parameter int OUT_BITWIDTH  = 8
);
  logic                            read_req_psum;
  logic        [ADDR_BITWIDTH-1:0] r_addr_psum;
  logic signed [DATA_BITWIDTH-1:0] r_data_psum;
  logic signed [OUT_BITWIDTH-1:0]  out_data;
  logic                            out_valid;
  logic                            out_ready;
  logic                            out_last;

  modport master (
    output read_req_psum,
    output r_addr_psum,
    input  r_data_psum,
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  read_req_psum,
    input  r_addr_psum,
    output r_data_psum,
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/psum_drain_requant.sv
// Drains NUM_PSUM psums from the GLB after start, requantises each to int8 and streams them out.
// First out_valid two edges after start, 1/cycle sustained; reads stall once two results are held.

module psum_drain_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_dat_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_dat_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Caller never writes when full nor reads when empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_ptr_q] <= wr_dat_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (rd_en_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({wr_en_i, rd_en_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_dat_o = mem_q[rd_ptr_q];
  assign count_o  = count_q;
endmodule

module psum_drain_requant #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10,
  parameter int OUT_BITWIDTH  = 8,
  parameter int PSUM_BASE     = 0,
  parameter int NUM_PSUM      = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 relu_en_i,
  input  logic [3:0]           shift_i,
  output logic                 busy_o,
  output logic                 done_o,
  psum_drain_requant_if.master bus_io
);
  localparam int CNT_W = $clog2(NUM_PSUM + 1);
  localparam int EXT_W = DATA_BITWIDTH + 1;
  localparam logic [CNT_W-1:0]         LAST_IDX  = CNT_W'(NUM_PSUM - 1);
  localparam logic [ADDR_BITWIDTH-1:0] BASE_ADDR = ADDR_BITWIDTH'(PSUM_BASE);
  localparam logic signed [EXT_W-1:0]  SAT_HI    = EXT_W'((2 ** (OUT_BITWIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0]  SAT_LO    = EXT_W'(-(2 ** (OUT_BITWIDTH - 1)));

  if (NUM_PSUM < 1) begin : g_bad_num_psum
    $error("psum_drain_requant: NUM_PSUM must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic       relu_en;
    logic [3:0] shift;
  } cfg_t;

  state_e                  state_q, state_d;
  cfg_t                    cfg_q, cfg_d;
  logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
  logic                    inflight_q, inflight_d;

  logic [1:0]              fifo_count;
  logic [1:0]              occ;
  logic                    issue;
  logic                    pop;
  logic [OUT_BITWIDTH-1:0] head_dat;
  logic [OUT_BITWIDTH-1:0] rq_dat;
  logic signed [EXT_W-1:0] psum_ext;
  logic signed [EXT_W-1:0] rnd_ext;
  logic signed [EXT_W-1:0] rq_full;

  // One extra bit of headroom keeps psum + rounding constant from overflowing.
  always_comb begin
    psum_ext = {bus_io.r_data_psum[DATA_BITWIDTH-1], bus_io.r_data_psum};
    rnd_ext  = '0;
    if (cfg_q.shift != 4'd0) rnd_ext = EXT_W'(1) << (cfg_q.shift - 4'd1);
    rq_full  = (psum_ext + rnd_ext) >>> cfg_q.shift;
    if (cfg_q.relu_en && (rq_full < 0)) rq_full = '0;
    if (rq_full > SAT_HI)      rq_dat = SAT_HI[OUT_BITWIDTH-1:0];
    else if (rq_full < SAT_LO) rq_dat = SAT_LO[OUT_BITWIDTH-1:0];
    else                       rq_dat = rq_full[OUT_BITWIDTH-1:0];
  end

  psum_drain_fifo #(
    .WIDTH (OUT_BITWIDTH),
    .DEPTH (2)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wr_en_i  (inflight_q),
    .wr_dat_i (rq_dat),
    .rd_en_i  (pop),
    .rd_dat_o (head_dat),
    .count_o  (fifo_count)
  );

  // A read in flight already owns a FIFO slot, so it counts toward occupancy.
  assign occ   = fifo_count + {1'b0, inflight_q};
  assign pop   = bus_io.out_valid && bus_io.out_ready;
  assign issue = (state_q == S_RUN) && ((occ < 2'd2) || ((occ == 2'd2) && pop));

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    inflight_d  = issue;
    if (issue) issue_cnt_d = issue_cnt_q + 1'b1;
    if (pop)   out_cnt_d   = out_cnt_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d       = S_RUN;
          cfg_d.relu_en = relu_en_i;
          cfg_d.shift   = shift_i;
          issue_cnt_d   = '0;
          out_cnt_d     = '0;
        end
      end
      S_RUN: begin
        if (issue && (issue_cnt_q == LAST_IDX)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((fifo_count == 2'd0) && !inflight_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cfg_q       <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      inflight_q  <= inflight_d;
    end
  end

  assign bus_io.read_req_psum = issue;
  assign bus_io.r_addr_psum   = issue ? (BASE_ADDR + ADDR_BITWIDTH'(issue_cnt_q)) : '0;
  assign bus_io.out_valid     = (fifo_count != 2'd0);
  assign bus_io.out_data      = head_dat;
  assign bus_io.out_last      = bus_io.out_valid && (out_cnt_q == LAST_IDX);
  assign busy_o               = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o               = (state_q == S_DONE);
endmodule

// File: tb/tb_psum_drain_requant.sv
// Directed bench for psum_drain_requant: behavioural GLB, read/output monitor, hand-computed results.
// A second instance with PSUM_BASE=1020 covers address wrap.
module tb_psum_drain_requant;
  localparam int DW  = 16;
  localparam int AW  = 10;
  localparam int OW  = 8;
  localparam int NUM = 9;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       start   = 1'b0;
  logic       start2  = 1'b0;
  logic       relu_en = 1'b0;
  logic [3:0] shift   = 4'd0;
  logic       busy, done, busy2, done2;

  psum_drain_requant_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .OUT_BITWIDTH(OW)) bus ();
  psum_drain_requant_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .OUT_BITWIDTH(OW)) bus2 ();

  psum_drain_requant #(
    .DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .OUT_BITWIDTH(OW), .PSUM_BASE(0), .NUM_PSUM(NUM)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .relu_en_i(relu_en), .shift_i(shift),
    .busy_o(busy), .done_o(done), .bus_io(bus)
  );

  psum_drain_requant #(
    .DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .OUT_BITWIDTH(OW), .PSUM_BASE(1020), .NUM_PSUM(NUM)
  ) dut_wrap (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .relu_en_i(relu_en), .shift_i(shift),
    .busy_o(busy2), .done_o(done2), .bus_io(bus2)
  );

  always #5 clk = ~clk;

  logic signed [DW-1:0] glb_mem [1024];

  always @(posedge clk) begin
    if (bus.read_req_psum)  bus.r_data_psum  <= glb_mem[bus.r_addr_psum];
    if (bus2.read_req_psum) bus2.r_data_psum <= glb_mem[bus2.r_addr_psum];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input integer got, input integer exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  int cyc = 0, rd_n = 0, acc_n = 0, done_n = 0, rd2_n = 0, acc2_n = 0, done2_n = 0;
  int occ = 0, max_occ = 0, last_acc_cyc = 0, done_cyc = 0;
  int addr_q[$], dat_q[$], last_q[$], addr2_q[$], dat2_q[$];

  // Logs every read, accept and done pulse one time unit after the falling edge.
  initial forever begin
    @(negedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      occ = 0;
    end else begin
      if (bus.read_req_psum) begin
        addr_q.push_back(int'(bus.r_addr_psum));
        rd_n++;
        occ++;
      end
      if (bus.out_valid && bus.out_ready) begin
        dat_q.push_back(int'(bus.out_data));
        last_q.push_back(int'(bus.out_last));
        acc_n++;
        occ--;
        last_acc_cyc = cyc;
      end
      if (occ > max_occ) max_occ = occ;
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (bus2.read_req_psum) begin
        addr2_q.push_back(int'(bus2.r_addr_psum));
        rd2_n++;
      end
      if (bus2.out_valid && bus2.out_ready) begin
        dat2_q.push_back(int'(bus2.out_data));
        acc2_n++;
      end
      if (done2) done2_n++;
    end
  end

  int set_a[NUM]  = '{10, -5, 300, -300, 127, 128, -129, 0, 7};
  int exp_a[NUM]  = '{10, -5, 127, -128, 127, 127, -128, 0, 7};
  int set_b[NUM]  = '{255, -24, 32767, -32768, 8, 7, -8, -9, 2040};
  int exp_b4[NUM] = '{16, -1, 127, -128, 1, 0, 0, -1, 127};
  int exp_br[NUM] = '{16, 0, 127, 0, 1, 0, 0, 0, 127};
  int exp_bf[NUM] = '{0, 0, 1, -1, 0, 0, 0, 0, 0};
  int exp_w[NUM]  = '{0, 0, 0, 0, 10, -5, 127, -128, 127};

  task automatic load(input int vals[NUM]);
    for (int i = 0; i < NUM; i++) glb_mem[i] = DW'(vals[i]);
  endtask

  // Returns on the falling edge right after start was captured; config is scrambled to prove latching.
  task automatic pulse_start(input logic r, input logic [3:0] sh);
    @(negedge clk);
    relu_en = r;
    shift   = sh;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    relu_en = ~r;
    shift   = ~sh;
  endtask

  task automatic wait_done(input string tag, input int b_done);
    int n = 0;
    while (done_n == b_done && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    check(tag, done_n - b_done, 1);
  endtask

  task automatic check_outs(input string tag, input int b, input int exp[NUM]);
    for (int i = 0; i < NUM; i++)
      check($sformatf("%s_dat%0d", tag, i), (b + i < dat_q.size()) ? dat_q[b + i] : 9999, exp[i]);
    check({tag, "_count"}, dat_q.size() - b, NUM);
  endtask

  int b_rd, b_acc, b_done, n;

  initial begin
    for (int i = 0; i < 1024; i++) glb_mem[i] = '0;
    bus.out_ready  = 1'b1;
    bus2.out_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    #2;
    check("rst_req",   bus.read_req_psum, 0);
    check("rst_vld",   bus.out_valid, 0);
    check("rst_dat",   bus.out_data, 0);
    check("rst_last",  bus.out_last, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: pass-through with saturation, latency and done timing
    load(set_a);
    b_rd = rd_n; b_acc = acc_n; b_done = done_n;
    pulse_start(1'b0, 4'd0);
    #2;
    check("t1_req_first",  bus.read_req_psum, 1);
    check("t1_addr_first", bus.r_addr_psum, 0);
    check("t1_busy",       busy, 1);
    @(negedge clk); #2;
    check("t1_vld_early",  bus.out_valid, 0);
    @(negedge clk); #2;
    check("t1_vld_first",  bus.out_valid, 1);
    check("t1_dat_first",  bus.out_data, 10);
    wait_done("t1_done", b_done);
    check_outs("t1", b_acc, exp_a);
    for (int i = 0; i < NUM; i++)
      check($sformatf("t1_last%0d", i), (b_acc + i < last_q.size()) ? last_q[b_acc + i] : 9, (i == NUM - 1) ? 1 : 0);
    check("t1_done_after_last", done_cyc - last_acc_cyc, 2);
    @(negedge clk); #2;
    check("t1_idle_busy", busy, 0);

    // 2: rounding shift, ReLU, and the largest shift
    load(set_b);
    b_acc = acc_n; b_done = done_n;
    pulse_start(1'b0, 4'd4);
    wait_done("t2a_done", b_done);
    check_outs("t2a", b_acc, exp_b4);
    b_acc = acc_n; b_done = done_n;
    pulse_start(1'b1, 4'd4);
    wait_done("t2b_done", b_done);
    check_outs("t2b", b_acc, exp_br);
    b_acc = acc_n; b_done = done_n;
    pulse_start(1'b0, 4'd15);
    wait_done("t2c_done", b_done);
    check_outs("t2c", b_acc, exp_bf);

    // 3: consumer stalled for 10 cycles after start
    load(set_a);
    b_rd = rd_n; b_acc = acc_n; b_done = done_n;
    bus.out_ready = 1'b0;
    pulse_start(1'b0, 4'd0);
    repeat (3) @(negedge clk);
    #2;
    check("t3_vld_stall", bus.out_valid, 1);
    check("t3_dat_early", bus.out_data, 10);
    repeat (6) @(negedge clk);
    #2;
    check("t3_reads_stall", rd_n - b_rd, 2);
    check("t3_dat_held",    bus.out_data, 10);
    check("t3_last_stall",  bus.out_last, 0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    wait_done("t3_done", b_done);
    check_outs("t3", b_acc, exp_a);
    check("t3_reads", rd_n - b_rd, NUM);

    // 4: toggling ready plus an ignored second start while busy
    b_rd = rd_n; b_acc = acc_n; b_done = done_n;
    pulse_start(1'b0, 4'd0);
    n = 0;
    while (done_n == b_done && n < 300) begin
      @(negedge clk);
      bus.out_ready = ~bus.out_ready;
      start = (n == 4);
      #2;
      n++;
    end
    start = 1'b0;
    bus.out_ready = 1'b1;
    check("t4_done", done_n - b_done, 1);
    repeat (6) @(negedge clk);
    #2;
    check("t4_reads", rd_n - b_rd, NUM);
    check("t4_done_once", done_n - b_done, 1);
    for (int i = 0; i < NUM; i++)
      check($sformatf("t4_addr%0d", i), (b_rd + i < addr_q.size()) ? addr_q[b_rd + i] : -1, i);
    check_outs("t4", b_acc, exp_a);
    check("t4_occ_le2", (max_occ <= 2) ? 1 : 0, 1);

    // 5: reset while the 4th output is presented
    b_acc = acc_n; b_done = done_n;
    pulse_start(1'b0, 4'd0);
    n = 0;
    while (acc_n - b_acc < 4 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("t5_reach4", acc_n - b_acc, 4);
    rst_n = 1'b0;
    #1;
    check("t5_rst_req",  bus.read_req_psum, 0);
    check("t5_rst_vld",  bus.out_valid, 0);
    check("t5_rst_dat",  bus.out_data, 0);
    check("t5_rst_last", bus.out_last, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("t5_no_done", done_n - b_done, 0);
    b_rd = rd_n; b_acc = acc_n; b_done = done_n;
    pulse_start(1'b0, 4'd0);
    #2;
    check("t5_restart_addr", bus.r_addr_psum, 0);
    wait_done("t5_done", b_done);
    check_outs("t5", b_acc, exp_a);

    // 6: address wrap on the PSUM_BASE=1020 instance
    b_rd = rd2_n; b_acc = acc2_n; b_done = done2_n;
    @(negedge clk);
    relu_en = 1'b0;
    shift   = 4'd0;
    start2  = 1'b1;
    @(negedge clk);
    start2  = 1'b0;
    n = 0;
    while (done2_n == b_done && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("t6_done", done2_n - b_done, 1);
    for (int i = 0; i < NUM; i++) begin
      check($sformatf("t6_addr%0d", i), (b_rd + i < addr2_q.size()) ? addr2_q[b_rd + i] : -1, (1020 + i) % 1024);
      check($sformatf("t6_dat%0d", i), (b_acc + i < dat2_q.size()) ? dat2_q[b_acc + i] : 9999, exp_w[i]);
    end
    check("t6_reads", rd2_n - b_rd, NUM);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
